// File: rtl/garo_trng_ctrl.sv
// Sequencer for the GARO ring-oscillator TRNG: warm-up, decimation, repetition-count health test.
// Optional von Neumann debiasing of raw sample pairs is enabled by defining GARO_VN_DEBIAS_EN.
module garo_trng_ctrl #(
    parameter int WORD_W     = 8,
    parameter int WARMUP     = 64,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rnd_in,
    output logic              osc_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              health_fail,
    input  logic              clear_fail
);
    localparam int WU_W  = $clog2(WARMUP + 1);
    localparam int DIV_W = $clog2(SAMPLE_DIV + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_t;

    state_t            state, state_nxt;
    logic [WU_W-1:0]   wu_cnt, wu_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic              prev_smp, prev_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [WORD_W-1:0] rd_data_nxt;
    logic              rd_valid_nxt, osc_en_nxt, health_fail_nxt;
    logic              smp_take, acc, acc_bit;
`ifdef GARO_VN_DEBIAS_EN
    logic              pair_full, pair_full_nxt;
    logic              pair_first, pair_first_nxt;
`endif

    always_comb begin
        state_nxt       = state;
        wu_nxt          = wu_cnt;
        div_nxt         = div_cnt;
        bit_nxt         = bit_cnt;
        run_nxt         = run_cnt;
        prev_nxt        = prev_smp;
        shreg_nxt       = shreg;
        rd_data_nxt     = rd_data;
        rd_valid_nxt    = rd_valid;
        health_fail_nxt = health_fail;
        smp_take        = 1'b0;
        acc             = 1'b0;
        acc_bit         = rnd_in;
`ifdef GARO_VN_DEBIAS_EN
        pair_full_nxt   = pair_full;
        pair_first_nxt  = pair_first;
`endif
        case (state)
            S_IDLE: begin
                if (enable) state_nxt = S_WARMUP;
            end
            S_WARMUP: begin
                if (!enable)
                    state_nxt = S_IDLE;
                else if (wu_cnt == WU_W'(WARMUP - 1))
                    state_nxt = S_COLLECT;
                else
                    wu_nxt = wu_cnt + WU_W'(1);
            end
            S_COLLECT: begin
                if (div_cnt == DIV_W'(SAMPLE_DIV - 1)) begin
                    div_nxt  = '0;
                    smp_take = 1'b1;
                    run_nxt  = (run_cnt != '0 && rnd_in == prev_smp) ? run_cnt + RUN_W'(1) : RUN_W'(1);
                    prev_nxt = rnd_in;
`ifdef GARO_VN_DEBIAS_EN
                    // 01 -> 0, 10 -> 1: the accepted bit is the first of the pair
                    if (!pair_full) begin
                        pair_full_nxt  = 1'b1;
                        pair_first_nxt = rnd_in;
                    end else begin
                        pair_full_nxt = 1'b0;
                        acc           = (pair_first != rnd_in);
                        acc_bit       = pair_first;
                    end
`else
                    acc = 1'b1;
`endif
                    if (acc) begin
                        shreg_nxt = {shreg[WORD_W-2:0], acc_bit};
                        bit_nxt   = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
                // Health failure outranks both enable drop and word completion
                if (smp_take && run_nxt == RUN_W'(REP_LIMIT)) begin
                    state_nxt       = S_FAIL;
                    health_fail_nxt = 1'b1;
                end else if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (acc && bit_cnt == BIT_W'(WORD_W - 1)) begin
                    state_nxt    = S_HOLD;
                    rd_data_nxt  = shreg_nxt;
                    rd_valid_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (rd_ready) begin
                    rd_valid_nxt = 1'b0;
                    state_nxt    = enable ? S_WARMUP : S_IDLE;
                end
            end
            S_FAIL: begin
                if (clear_fail) begin
                    health_fail_nxt = 1'b0;
                    state_nxt       = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (state_nxt == S_WARMUP && state != S_WARMUP) begin
            wu_nxt  = '0;
            run_nxt = '0;
            bit_nxt = '0;
        end
        if (state_nxt == S_COLLECT && state != S_COLLECT) begin
            div_nxt = '0;
`ifdef GARO_VN_DEBIAS_EN
            pair_full_nxt = 1'b0;
`endif
        end
        osc_en_nxt = (state_nxt == S_WARMUP) || (state_nxt == S_COLLECT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wu_cnt      <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            run_cnt     <= '0;
            prev_smp    <= 1'b0;
            shreg       <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            osc_en      <= 1'b0;
            health_fail <= 1'b0;
`ifdef GARO_VN_DEBIAS_EN
            pair_full   <= 1'b0;
            pair_first  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            wu_cnt      <= wu_nxt;
            div_cnt     <= div_nxt;
            bit_cnt     <= bit_nxt;
            run_cnt     <= run_nxt;
            prev_smp    <= prev_nxt;
            shreg       <= shreg_nxt;
            rd_data     <= rd_data_nxt;
            rd_valid    <= rd_valid_nxt;
            osc_en      <= osc_en_nxt;
            health_fail <= health_fail_nxt;
`ifdef GARO_VN_DEBIAS_EN
            pair_full   <= pair_full_nxt;
            pair_first  <= pair_first_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_garo_trng_ctrl.sv
// Directed + randomized bench for garo_trng_ctrl (default build, REP_LIMIT set to WORD_W
// so a constant word also hits the health limit on its last sample).
module tb_garo_trng_ctrl;
    localparam int WORD_W     = 8;
    localparam int WARMUP     = 64;
    localparam int SAMPLE_DIV = 4;
    localparam int REP_LIMIT  = 8;
    localparam int FIRST_SMP  = WARMUP + SAMPLE_DIV;          // edge of first sample
    localparam int LAST_EDGE  = WARMUP + WORD_W * SAMPLE_DIV;  // edge loading rd_data

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              enable = 1'b0;
    logic              rnd_in = 1'b0;
    logic              osc_en;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic              health_fail;
    logic              clear_fail = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    garo_trng_ctrl #(
        .WORD_W(WORD_W), .WARMUP(WARMUP), .SAMPLE_DIV(SAMPLE_DIV), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rnd_in(rnd_in),
        .osc_en(osc_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .health_fail(health_fail), .clear_fail(clear_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word from IDLE. mode 0: random, 1: samples 1,0,1,0..., 2: stuck at 1.
    task automatic do_word(input int mode, input int hold, input bit rst_in_hold);
        bit                rv[LAST_EDGE+1];
        bit                smp[WORD_W];
        logic [WORD_W-1:0] exp_word;
        int                run, fail_k, last;
        for (int e = 0; e <= LAST_EDGE; e++) begin
            if (mode == 2) rv[e] = 1'b1;
            else if (mode == 1 && e >= FIRST_SMP && (e - FIRST_SMP) % SAMPLE_DIV == 0)
                rv[e] = (((e - FIRST_SMP) / SAMPLE_DIV) % 2 == 0);
            else rv[e] = 1'($urandom_range(0, 1));
        end
        exp_word = '0;
        fail_k   = -1;
        run      = 0;
        for (int k = 0; k < WORD_W; k++) begin
            smp[k]   = rv[FIRST_SMP + k * SAMPLE_DIV];
            exp_word = {exp_word[WORD_W-2:0], smp[k]};
            run      = (k > 0 && smp[k] == smp[k-1]) ? run + 1 : 1;
            if (run >= REP_LIMIT && fail_k < 0) fail_k = k;
        end
        last = (fail_k >= 0) ? FIRST_SMP + fail_k * SAMPLE_DIV : LAST_EDGE;

        enable   = 1'b1;
        rd_ready = 1'b0;
        for (int e = 0; e <= last; e++) begin
            rnd_in = rv[e];
            tick();
            if (e < last) begin
                chk("osc_en_run", osc_en, 1);
                chk("rd_valid_run", rd_valid, 0);
                chk("health_run", health_fail, 0);
            end
        end
        chk("osc_en_end", osc_en, 0);
        if (fail_k >= 0) begin
            chk("fail_rd_valid", rd_valid, 0);
            chk("fail_flag", health_fail, 1);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("fail_sticky", health_fail, 1);
                chk("fail_osc", osc_en, 0);
                chk("fail_rd_valid_hold", rd_valid, 0);
            end
            clear_fail = 1'b1;
            enable     = 1'b0;
            tick();
            clear_fail = 1'b0;
            chk("clear_fail", health_fail, 0);
            tick();
            chk("idle_osc_after_clear", osc_en, 0);
            chk("idle_health_after_clear", health_fail, 0);
            return;
        end
        chk("word_valid", rd_valid, 1);
        chk("word_data", rd_data, exp_word);
        for (int h = 0; h < hold; h++) begin
            enable     = 1'($urandom_range(0, 1));
            clear_fail = 1'($urandom_range(0, 1));
            rnd_in     = 1'($urandom_range(0, 1));
            tick();
            chk("hold_valid", rd_valid, 1);
            chk("hold_data", rd_data, exp_word);
            chk("hold_osc", osc_en, 0);
            chk("hold_health", health_fail, 0);
        end
        clear_fail = 1'b0;
        if (rst_in_hold) begin
            #2 reset_n = 1'b0;
            #1;
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_osc", osc_en, 0);
            chk("rst_rd_data", rd_data, 0);
            #2 reset_n = 1'b1;
            enable = 1'b0;
            tick();
            chk("rst_idle_osc", osc_en, 0);
            return;
        end
        rd_ready = 1'b1;
        enable   = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("ack_valid_low", rd_valid, 0);
        chk("ack_rewarm", osc_en, 1);
        enable = 1'b0;
        tick();
        chk("warm_drop_osc", osc_en, 0);
    endtask

    // Enable is sampled low at edge e_drop (counted from the enabling edge 0).
    task automatic drop_at(input int e_drop);
        enable = 1'b1;
        for (int e = 0; e <= e_drop; e++) begin
            enable = (e < e_drop);
            rnd_in = 1'($urandom_range(0, 1));
            tick();
            chk("drop_rd_valid", rd_valid, 0);
            chk("drop_osc", osc_en, (e < e_drop) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("drop_idle_osc", osc_en, 0);
            chk("drop_idle_valid", rd_valid, 0);
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        chk("reset_osc", osc_en, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_health", health_fail, 0);
        chk("reset_data", rd_data, 0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        chk("idle_osc", osc_en, 0);

        do_word(1, 0, 1'b0);                 // alternating samples -> 8'hAA
        do_word(0, 50, 1'b0);                // long back-pressure
        do_word(2, 0, 1'b0);                 // stuck-at-1 -> health failure
        drop_at(FIRST_SMP + 4 * SAMPLE_DIV); // enable dropped at the 5th sample
        do_word(0, 2, 1'b0);                 // full warm-up after re-enable
        drop_at(30);                         // enable dropped during warm-up
        do_word(0, 3, 1'b1);                 // reset while holding a word
        for (int n = 0; n < 20; n++)
            do_word(0, $urandom_range(0, 5), 1'b0);
        do_word(2, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
